// File: rtl/spi_shifter.sv
// SPI master shift engine, mode 0 (sck idles low).
// Bit timing comes from a free-running sck_in supplied by an external divider.
// sck_in is synchronized into clk and turned into single-cycle rise/fall events.
// The FSM walks IDLE -> LEAD -> XFER -> TRAIL -> DONE, and every output is registered.
module spi_shifter #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sck_in,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             miso,
    output logic             sck,
    output logic             mosi,
    output logic             cs_n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;

    state_t           state_q;
    logic             sync1_q, sync2_q, hist_q;
    logic [WIDTH-1:0] tx_q, rx_q, rx_data_q;
    logic [CW-1:0]    bit_cnt_q;
    logic             sck_q, mosi_q, cs_n_q, busy_q, done_q;

    logic             rise_evt, fall_evt;
    logic             first_bit_d, next_bit_d, last_bit_d;
    logic [WIDTH-1:0] tx_d, rx_d;

    // Two-flop synchronizer plus a history flop for edge detection on sck_in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sck_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise_evt = sync2_q & ~hist_q;
    assign fall_evt = ~sync2_q & hist_q;

    // Bit-order-dependent shift paths. The transmit word shifts out at the head.
    // Received bits enter at the opposite end.
    assign first_bit_d = LSB_FIRST ? tx_data[0] : tx_data[WIDTH-1];
    assign tx_d        = LSB_FIRST ? (tx_q >> 1) : (tx_q << 1);
    assign next_bit_d  = LSB_FIRST ? tx_q[1] : tx_q[WIDTH-2];
    assign rx_d        = LSB_FIRST ? {miso, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], miso};
    assign last_bit_d  = (bit_cnt_q == CW'(WIDTH - 1));

    // Transfer FSM with registered SPI pins and status outputs.
    // abort overrides every edge event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != IDLE) begin
                state_q <= IDLE;
                sck_q   <= 1'b0;
                mosi_q  <= 1'b0;
                cs_n_q  <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            tx_q      <= tx_data;
                            bit_cnt_q <= '0;
                            cs_n_q    <= 1'b0;
                            mosi_q    <= first_bit_d;
                            busy_q    <= 1'b1;
                            state_q   <= LEAD;
                        end
                    end
                    // Waiting for a falling edge gives cs_n at least half a bit of setup before the first sck rise.
                    LEAD: begin
                        if (fall_evt) state_q <= XFER;
                    end
                    XFER: begin
                        if (rise_evt) begin
                            sck_q <= 1'b1;
                            rx_q  <= rx_d;
                        end else if (fall_evt) begin
                            sck_q <= 1'b0;
                            if (last_bit_d) begin
                                state_q <= TRAIL;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                tx_q      <= tx_d;
                                mosi_q    <= next_bit_d;
                            end
                        end
                    end
                    // The done strobe is raised on entry, so it lines up with the DONE cycle itself.
                    TRAIL: begin
                        if (rise_evt) begin
                            cs_n_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            rx_data_q <= rx_q;
                            state_q   <= DONE;
                        end
                    end
                    DONE: begin
                        mosi_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule
